// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: N-digit BCD countdown/count-up timer with keypad preset
// entry, start/pause/clear control, terminal-count pulse and timed alarm window.
//
// Parameters:
//   DIGITS      number of BCD digits (1..8)
//   TICK_DIV    clock cycles per count tick (>= 2)
//   ALARM_TICKS count ticks the alarm window lasts (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   key_num    keypad code, 0..9 are digits
//   key_valid  one-cycle strobe qualifying key_num
//   cmd_start  start / resume strobe
//   cmd_pause  pause strobe
//   cmd_clear  abort and zero the preset
//   mode_up    count direction sampled at start from IDLE (1 = up)
//   bcd        displayed value, digit 0 in bits [3:0]
//   running    high while counting
//   done       one-cycle pulse when the terminal value is reached
//   alarm      high throughout the alarm window
//   bi         display blank, toggles each tick during the alarm window
module bcd_countdown_timer #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned ALARM_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            key_num,
  input  logic                  key_valid,
  input  logic                  cmd_start,
  input  logic                  cmd_pause,
  input  logic                  cmd_clear,
  input  logic                  mode_up,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  running,
  output logic                  done,
  output logic                  alarm,
  output logic                  bi
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AW = $clog2(ALARM_TICKS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   preset_q, preset_d;
  logic           dir_q, dir_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [AW-1:0]  acnt_q, acnt_d;
  logic           running_q, running_d;
  logic           done_q, done_d;
  logic           alarm_q, alarm_d;
  logic           bi_q, bi_d;

  logic           tick;
  logic           advance;
  logic [PW-1:0]  presc_inc;
  logic [W-1:0]   count_step;
  logic [W-1:0]   term;
  logic [W-1:0]   key_shift;

  // BCD decrement with digit-wise borrow: 0 becomes 9 and borrows onward.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD increment with digit-wise carry: 9 becomes 0 and carries onward.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Datapath helpers shared by the next-state logic.
  assign tick       = (presc_q == PW'(TICK_DIV - 1));
  assign presc_inc  = tick ? '0 : presc_q + PW'(1);
  assign count_step = dir_q ? bcd_inc(count_q) : bcd_dec(count_q);
  assign term       = dir_q ? preset_q : '0;
  // Shift the new digit in from the right; the top digit falls off.
  assign key_shift  = W'({count_q, key_num});

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      preset_q  <= '0;
      dir_q     <= 1'b0;
      presc_q   <= '0;
      acnt_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
      bi_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      preset_q  <= preset_d;
      dir_q     <= dir_d;
      presc_q   <= presc_d;
      acnt_q    <= acnt_d;
      running_q <= running_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
      bi_q      <= bi_d;
    end
  end

  // Next-state and next-output logic; only the highest-priority command acts.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    preset_d = preset_q;
    dir_d    = dir_q;
    presc_d  = presc_q;
    acnt_d   = acnt_q;
    bi_d     = bi_q;
    done_d   = 1'b0;
    advance  = 1'b0;

    if (cmd_clear) begin
      state_d  = ST_IDLE;
      count_d  = '0;
      preset_d = '0;
      presc_d  = '0;
      acnt_d   = '0;
      bi_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_d = '0;
          acnt_d  = '0;
          bi_d    = 1'b0;
          if (!cmd_pause) begin
            if (cmd_start) begin
              if (preset_q != '0) begin
                state_d = ST_RUN;
                dir_d   = mode_up;
                count_d = mode_up ? '0 : preset_q;
              end
            end else if (key_valid && (key_num <= 4'd9)) begin
              count_d  = key_shift;
              preset_d = key_shift;
            end
          end
        end
        ST_RUN: begin
          if (cmd_pause) begin
            state_d = ST_PAUSE;
          end else begin
            advance = 1'b1;
          end
        end
        ST_PAUSE: begin
          // The resume edge counts as a running cycle so the delay added
          // equals the number of cycles spent paused.
          if (!cmd_pause && cmd_start) begin
            state_d = ST_RUN;
            advance = 1'b1;
          end
        end
        ST_ALARM: begin
          presc_d = presc_inc;
          if (tick) begin
            bi_d = ~bi_q;
            if (acnt_q == AW'(ALARM_TICKS - 1)) begin
              state_d = ST_IDLE;
              bi_d    = 1'b0;
              acnt_d  = '0;
              count_d = preset_q;
            end else begin
              acnt_d = acnt_q + AW'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // One running cycle: advance the prescaler, count on tick.
      if (advance) begin
        presc_d = presc_inc;
        if (tick) begin
          count_d = count_step;
          if (count_step == term) begin
            state_d = ST_ALARM;
            done_d  = 1'b1;
            bi_d    = 1'b1;
            acnt_d  = '0;
          end
        end
      end
    end

    running_d = (state_d == ST_RUN);
    alarm_d   = (state_d == ST_ALARM);
  end

  assign bcd     = count_q;
  assign running = running_q;
  assign done    = done_q;
  assign alarm   = alarm_q;
  assign bi      = bi_q;

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Parametrised N-digit BCD countdown/count-up timer core with keypad preset entry, start/pause/clear control, a terminal-count pulse and a timed alarm window. It is the successor to the fixed 4-digit, 1-second countdown built from separate controller and counter blocks. It sits between the keyboard block (digit and command inputs) and the seven-segment and buzzer blocks (BCD display, blanking, alarm enable). It adds generic digit count, a configurable tick period, an up-count mode, pause/resume and preset reload.

## Interface
- DIGITS, 4: number of BCD digits; legal range 1..8.
- TICK_DIV, 50000000: clock cycles per count tick; minimum 2.
- ALARM_TICKS, 3: number of ticks the alarm window lasts; minimum 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- key_num  in  4  keypad code; only values 0..9 are digits.
- key_valid  in  1  one-cycle strobe qualifying key_num.
- cmd_start  in  1  one-cycle strobe: start or resume.
- cmd_pause  in  1  one-cycle strobe: pause.
- cmd_clear  in  1  one-cycle strobe: abort and zero the preset.
- mode_up  in  1  count direction, sampled at start from IDLE: 0 = down, 1 = up.
- bcd  out  4*DIGITS  displayed value; digit 0 is bits [3:0] (least significant).
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse when the terminal value is reached.
- alarm  out  1  high throughout ALARM; drives buzzer enable.
- bi  out  1  display blank; flashes during ALARM.

## Operation
- States are IDLE, RUN, PAUSE and ALARM. The block holds a preset register, a count register (bcd), a direction flag, a prescaler (0..TICK_DIV-1) and an alarm tick counter.
- Command priority in the same cycle: cmd_clear > cmd_pause > cmd_start > key_valid.
- cmd_clear, in any state: go to IDLE; preset = count = 0; prescaler = 0; alarm = bi = 0; no done pulse.
- IDLE, key_valid with key_num ≤ 9: shift in from the right. Count = {count[4*DIGITS-5:0], key_num}; the most significant digit is discarded; preset gets the same value. key_num ≥ 10 is ignored. Keys are ignored in all other states.
- IDLE, cmd_start with preset ≠ 0: go to RUN and latch the direction from mode_up; prescaler = 0.
  - Down mode: count = preset. Terminal value = 0.
  - Up mode: count = 0. Terminal value = preset.
  - cmd_start with preset = 0 is ignored.
- RUN: the prescaler increments each cycle. When it equals TICK_DIV-1, a tick occurs and the prescaler wraps to 0.
  - Down tick: BCD decrement. A digit at 0 becomes 9 and borrows from the next digit.
  - Up tick: BCD increment. A digit at 9 becomes 0 and carries into the next digit.
  - When the new count equals the terminal value: go to ALARM and pulse done.
- RUN with cmd_pause: go to PAUSE; prescaler and count are frozen. PAUSE with cmd_start: return to RUN with the prescaler resumed from its held value. Pause outside RUN is ignored.
- ALARM: alarm = 1. The prescaler keeps running. Each tick toggles bi and increments the alarm counter. After ALARM_TICKS ticks: go to IDLE, alarm = 0, bi = 0, and count reloads preset. cmd_start and keys are ignored in ALARM.
- All values stay valid BCD at all times. No digit ever exceeds 9.

## Timing
- Reset values: state IDLE; bcd 0; preset 0; prescaler 0; running 0, done 0, alarm 0, bi 0.
- All outputs are registered.
- Start accepted at edge E: running = 1 after E. The first tick updates bcd at edge E+TICK_DIV. Count k is shown after E + k·TICK_DIV.
- The tick that reaches the terminal value has these outputs after the same edge: bcd = terminal value, done = 1 (for one cycle), alarm = 1, running = 0, bi = 1. bi toggles at each following tick. Alarm falls, and bcd shows the preset, at terminal edge + ALARM_TICKS·TICK_DIV.
- A tick and cmd_pause in the same cycle: pause wins; no count update.
- A tick and cmd_clear in the same cycle: clear wins; no done pulse.
- Reset asserted mid-count or mid-alarm: all outputs return to their reset values immediately, without waiting for a clock edge.
- Key entry is one update per key_valid cycle. Back-to-back strobes are all accepted.

## Test plan
All scenarios use TICK_DIV = 4 and DIGITS = 4.
- Keys 1,2,0,5 then 7 → bcd = 0x2057; preset 2057. Key 11 → unchanged.
- Preset 0003, down mode, start → bcd 0002/0001/0000 at +4/+8/+12 cycles. done pulses once together with 0000. alarm high for 12 cycles with bi toggling. Then bcd = 0003.
- Preset 0100, down → after the first tick bcd = 0099 (borrow chain). Up mode with preset 0010 → 0009 → 0010, done asserted.
- Pause after 2 ticks, hold 20 cycles, then start → the remaining ticks resume with the held prescaler phase, and the total elapsed time is extended by exactly the pause length.
- Start with preset 0 → stays IDLE, running = 0. cmd_clear during ALARM → alarm = 0, bcd = 0, no extra done pulse.
- Reset pulse mid-RUN (not aligned to a clock edge) → all outputs are 0 immediately. Subsequent key entry works normally.
